// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the LEGv8 pipeline front end.
package cpu_pkg;

    // Fetch-stage control state. HALTED is only entered on a fetch fault.
    typedef enum logic [0:0] {
        FETCH,
        HALTED
    } fetch_state_t;

    // Encoding placed in if_id_instr for a bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0;

    // IF/ID pipeline register payload.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    // A bubble carries no PC, a NOP and valid = 0.
    localparam if_id_t IF_ID_BUBBLE = '{pc: 64'h0, instr: NOP_INSTR, valid: 1'b0};

    // Instructions are 4-byte aligned.
    function automatic logic is_word_aligned(input logic [63:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold and bubble controls.
// Synchronous active-high reset clears it to a bubble.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_r;

    // Bubble outranks load; with neither asserted the register holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= IF_ID_BUBBLE;
        end else if (bubble) begin
            q_r <= IF_ID_BUBBLE;
        end else if (load) begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: LEGv8 instruction-fetch stage. Owns the PC, addresses the
// combinational instruction ROM and fills the IF/ID register, honouring
// stall, flush and branch redirects.
// Optional feature: define FETCH_BOUNDS_CHECK_EN to halt on misaligned or
// out-of-range fetches and raise the sticky fetch_fault flag.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        fetch_fault
);

    if (IMEM_BYTES <= 4 || (IMEM_BYTES & (IMEM_BYTES - 1)) != 0) begin : g_bad_imem_bytes
        $error("fetch_stage: IMEM_BYTES must be a power of two greater than 4");
    end

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  pc_inc;
    logic         fault;
    logic         ifid_load;
    logic         ifid_bubble;
    if_id_t       ifid_d, ifid_q;

    assign pc_inc = pc_q + 64'd4;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [64:0] IMEM_LIMIT = 65'(IMEM_BYTES);

    logic [63:0] pc_cand;
    logic [64:0] pc_last_byte;
    logic        fault_q;

    // PC the non-faulting priority chain would load; flush+stall holds like stall.
    assign pc_cand      = br_taken ? br_target : (stall ? pc_q : pc_inc);
    // Widened so a PC near the top of the address space cannot wrap past the check.
    assign pc_last_byte = {1'b0, pc_q} + 65'd3;
    assign fault        = (state_q == FETCH)
                          && (!is_word_aligned(pc_cand) || pc_last_byte >= IMEM_LIMIT);

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (fault) begin
            fault_q <= 1'b1;
        end
    end

    assign fetch_fault = fault_q;
`else
    assign fault       = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a fault halts fetch until reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:  if (fault) state_d = HALTED;
            HALTED: state_d = HALTED;
        endcase
    end

    // Outputs: next PC and IF/ID control, in priority fault > branch > flush > stall.
    always_comb begin
        pc_d        = pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (fault) begin
                    // PC keeps its pre-fault value so software can see where it stopped.
                    ifid_bubble = 1'b1;
                end else if (br_taken) begin
                    // Current fetch is wrong-path; drop it.
                    pc_d        = br_target;
                    ifid_bubble = 1'b1;
                end else if (flush) begin
                    ifid_bubble = 1'b1;
                    if (!stall) begin
                        pc_d = pc_inc;
                    end
                end else if (!stall) begin
                    pc_d      = pc_inc;
                    ifid_load = 1'b1;
                end
            end
            HALTED: begin
                ifid_bubble = 1'b1;
            end
        endcase
    end

    // Program counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign imem_addr = pc_q;

    assign ifid_d = '{pc: pc_q, instr: imem_instr, valid: 1'b1};

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign if_id_pc    = ifid_q.pc;
    assign if_id_instr = ifid_q.instr;
    assign if_id_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan steps followed by randomized
// stall/flush/branch/reset traffic, checked against a behavioural model.
module tb_fetch_stage;

    localparam logic [63:0] RESET_PC   = 64'h0;
    localparam int unsigned IMEM_BYTES = 1024;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [63:0] br_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_fault;

    always #5 clk = ~clk;

    // ROM contents: a scrambled function of the address, so each word is distinct.
    function automatic logic [31:0] rom_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_instr = rom_word(imem_addr);

    fetch_stage #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .fetch_fault (fetch_fault)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [63:0] m_pc;
    logic [63:0] m_if_pc;
    logic [31:0] m_if_instr;
    logic        m_if_valid;
    logic        m_halted;
    logic        m_fault;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_bubble();
        m_if_pc    = 64'h0;
        m_if_instr = 32'h0;
        m_if_valid = 1'b0;
    endtask

    // One clock edge of the fetch stage, written from the behavioural rules.
    task automatic model_edge();
        logic [63:0] nxt;
        logic        bad;
        if (reset) begin
            m_pc     = RESET_PC;
            m_halted = 1'b0;
            m_fault  = 1'b0;
            m_bubble();
        end else if (m_halted) begin
            m_bubble();
        end else begin
            if (br_taken)   nxt = br_target;
            else if (stall) nxt = m_pc;
            else            nxt = m_pc + 64'd4;
            bad = CHECK_EN && ((nxt % 64'd4) != 64'd0 || m_pc >= 64'(IMEM_BYTES - 3));
            if (bad) begin
                m_halted = 1'b1;
                m_fault  = 1'b1;
                m_bubble();
            end else if (br_taken) begin
                m_pc = br_target;
                m_bubble();
            end else if (flush) begin
                m_pc = nxt;
                m_bubble();
            end else if (!stall) begin
                m_if_pc    = m_pc;
                m_if_instr = rom_word(m_pc);
                m_if_valid = 1'b1;
                m_pc       = nxt;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".if_id_pc"}, if_id_pc, m_if_pc);
        chk({tag, ".if_id_instr"}, 64'(if_id_instr), 64'(m_if_instr));
        chk({tag, ".if_id_valid"}, 64'(if_id_valid), 64'(m_if_valid));
        chk({tag, ".fetch_fault"}, 64'(fetch_fault), 64'(m_fault));
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic b,
                         input logic [63:0] t);
        reset     = r;
        stall     = s;
        flush     = f;
        br_taken  = b;
        br_target = t;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish by 200000, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] tgt;
        m_pc = RESET_PC;
        m_halted = 1'b0;
        m_fault = 1'b0;
        m_bubble();

        // Reset for two cycles.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        step("reset0");
        step("reset1");
        chk("reset.addr_is_0", imem_addr, 64'h0);
        chk("reset.valid_is_0", 64'(if_id_valid), 64'h0);

        // First fetches after release.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        step("fetch0");
        chk("fetch0.pc_is_0", if_id_pc, 64'h0);
        step("fetch1");
        chk("fetch1.pc_is_4", if_id_pc, 64'h4);

        // Stall three cycles with pc = 8.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        repeat (3) step("stall");
        chk("stall.addr_is_8", imem_addr, 64'h8);
        chk("stall.hold_pc_4", if_id_pc, 64'h4);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        step("resume");
        chk("resume.pc_is_8", if_id_pc, 64'h8);

        // Branch to 0x40 from pc = 0xC.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h40);
        step("branch");
        chk("branch.addr_is_40", imem_addr, 64'h40);
        chk("branch.bubble", 64'(if_id_valid), 64'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        step("branch_tgt");
        chk("branch_tgt.pc_is_40", if_id_pc, 64'h40);

        // Branch and stall together: redirect wins.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h80);
        step("br_stall");
        chk("br_stall.addr_is_80", imem_addr, 64'h80);
        chk("br_stall.bubble", 64'(if_id_valid), 64'h0);

        // Flush alone, then flush with stall.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        step("pre_flush");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        step("flush");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        step("flush_stall");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        step("post_flush");

        // Reset asserted mid-stall and mid-branch.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 64'h200);
        step("reset_mid");
        chk("reset_mid.addr_is_0", imem_addr, 64'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        step("after_reset_mid");

        // Misaligned branch target.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h42);
        step("misalign");
`ifdef FETCH_BOUNDS_CHECK_EN
        chk("misalign.fault", 64'(fetch_fault), 64'h1);
        chk("misalign.pc_holds", imem_addr, 64'h4);
`else
        chk("misalign.passes", imem_addr, 64'h42);
`endif
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 64'h100);
            step("after_misalign");
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        step("fault_reset");
        chk("fault_reset.clear", 64'(fetch_fault), 64'h0);
        chk("fault_reset.addr_is_0", imem_addr, 64'h0);

        // Sequential run up to the end of the ROM.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 300 && m_pc != 64'h400; i++) begin
            step("seq");
        end
        step("seq_end");
`ifdef FETCH_BOUNDS_CHECK_EN
        chk("seq_end.fault", 64'(fetch_fault), 64'h1);
        chk("seq_end.no_valid", 64'(if_id_valid), 64'h0);
        chk("seq_end.pc_holds", imem_addr, 64'h400);
`else
        chk("seq_end.pc_400", if_id_pc, 64'h400);
        chk("seq_end.valid", 64'(if_id_valid), 64'h1);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            tgt = 64'($urandom_range(0, 511)) << 2;
            if ($urandom_range(0, 9) == 0) tgt = tgt | 64'($urandom_range(1, 3));
            drive(($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 3) == 0),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0,
                  tgt);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined LEGv8 CPU. Owns the program counter and drives the byte address into the combinational instruction ROM. Registers the returned 32-bit instruction with its PC into the IF/ID pipeline register, and honours stall, flush and branch-redirect requests from downstream stages.

## Interface
Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- IMEM_BYTES, 1024, instruction ROM size in bytes. Must be a power of two and greater than 4.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit hold request; PC and IF/ID both hold.
- flush  input  1  squash the IF/ID contents, i.e. load a bubble next edge.
- br_taken  input  1  redirect request from the branch-resolution stage.
- br_target  input  64  redirect byte address.
- imem_addr  output  64  byte address to the ROM; equals the current PC, combinational.
- imem_instr  input  32  ROM read data for imem_addr, same cycle.
- if_id_pc  output  64  PC of the registered instruction.
- if_id_instr  output  32  registered instruction.
- if_id_valid  output  1  1 means if_id_instr is a real fetched instruction; 0 means bubble.
- fetch_fault  output  1  sticky fault flag; only present when compiled in, otherwise tied 0.

## Operation
- State machine: FETCH and HALTED. Reset enters FETCH. A fault moves the block from FETCH to HALTED. HALTED exits only on reset.
- Per-edge priority: reset, then fault detection, then br_taken, then flush, then stall, then normal fetch.
- Normal fetch:
  - pc <= pc + 4, wrapping modulo 2^64.
  - if_id_pc <= pc, if_id_instr <= imem_instr, if_id_valid <= 1.
- br_taken:
  - pc <= br_target.
  - IF/ID loads a bubble, because the current fetch is wrong-path.
  - br_taken overrides a simultaneous stall.
- flush without br_taken:
  - pc advances normally.
  - IF/ID loads a bubble.
  - flush overrides stall; PC holds if stall is also asserted.
- stall alone: pc, if_id_pc, if_id_instr and if_id_valid all hold.
- Bubble encoding: if_id_valid = 0, if_id_instr = 32'h0, if_id_pc = 0.
- HALTED: pc holds, IF/ID emits bubbles every cycle, and all inputs except reset are ignored.

## Timing
- Reset values: pc = RESET_PC, imem_addr = RESET_PC, if_id_pc = 0, if_id_instr = 0, if_id_valid = 0, fetch_fault = 0, state = FETCH.
- Fetch latency: one cycle. The instruction at PC p appears on IF/ID the edge after imem_addr = p.
- Branch penalty: one bubble cycle when br_taken is asserted for one cycle.
- Reset asserted mid-stall or mid-branch: takes effect at that edge; all other inputs are ignored.
- First valid IF/ID output arrives one edge after reset deasserts.

## Configuration
- Macro: FETCH_BOUNDS_CHECK_EN.
- When defined, a fault is raised at the edge where any of the following holds:
  - the next PC would have pc[1:0] != 0 (a misaligned br_target);
  - the current pc + 3 >= IMEM_BYTES while fetching.
- On a fault: fetch_fault <= 1, the state machine goes to HALTED, IF/ID loads a bubble, and pc holds its pre-fault value.
- When undefined: there is no checking, fetch_fault is constant 0, HALTED is unreachable, and out-of-range or misaligned addresses pass through to the ROM unchanged.

## Structure
- Shared package cpu_pkg holds:
  - fetch_state_t, the enum {FETCH, HALTED};
  - the NOP_INSTR constant, 32'h0;
  - the if_id_t struct {pc, instr, valid}.
- One sub-module, if_id_reg: the pipeline register with load, hold, and bubble controls and synchronous reset. It is instantiated once.

## Test plan
- Reset for 2 cycles, then release. Required: imem_addr = 0, if_id_valid = 0 during reset; if_id_pc = 0, 4, 8 on the following edges with valid = 1.
- stall held 3 cycles while pc = 8. Required: imem_addr stays 8, IF/ID holds pc 4, and fetch resumes with pc 8 on the following edge.
- br_taken with br_target = 0x40 while pc = 0xC. Required: next edge gives a bubble and imem_addr = 0x40; the following edge gives if_id_pc = 0x40.
- br_taken and stall together, target 0x80. Required: the redirect wins, pc = 0x80, IF/ID is a bubble.
- With FETCH_BOUNDS_CHECK_EN, br_target = 0x42. Required: fetch_fault = 1, HALTED, bubbles thereafter, pc holds; reset clears fetch_fault and pc = 0.
- With FETCH_BOUNDS_CHECK_EN and IMEM_BYTES = 1024, run sequentially to pc = 0x400. Required: fault raised, no valid IF/ID with pc 0x400. Without the macro: if_id_pc = 0x400 with valid = 1.
